// File: rtl/bus_arbiter_rr_n.sv
// bus_arbiter_rr_n: N-master round-robin bus arbiter with parking, bounded-hold preemption and lock.
module bus_arbiter_rr_n #(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_W     = 2,
    parameter int HOLD_W      = 8,
    parameter int MAX_HOLD    = 16,
    parameter int PARK_MASTER = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] lock,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [OWNER_W-1:0]     owner,
    output logic                   handover
);
    localparam logic [HOLD_W-1:0]  HOLD_TOP = MAX_HOLD == 0 ? '0 : HOLD_W'(MAX_HOLD - 1);
    localparam logic [OWNER_W-1:0] PARK     = OWNER_W'(PARK_MASTER);
    logic [HOLD_W-1:0]      hold_cnt, hold_nxt;
    logic [OWNER_W-1:0]     next, owner_nxt;
    logic [NUM_MASTERS-1:0] rot;
    logic                   found, valid, own_req, preempt;
    int                     s;
    assign grant   = NUM_MASTERS'(1) << owner;
    assign valid   = int'(owner) < NUM_MASTERS;
    // rot[k] is the request of master (owner+k) mod N, so bit 0 is the owner itself
    assign rot     = NUM_MASTERS'({req, req} >> owner);
    assign found   = |rot[NUM_MASTERS-1:1];
    assign own_req = rot[0];
    always_comb begin
        next = owner;
        s = 0;
        for (int k = NUM_MASTERS - 1; k >= 1; k--) begin
            s = int'(owner) + k;
            if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
            if (rot[k]) next = OWNER_W'(s);
        end
    end
    assign preempt   = own_req && MAX_HOLD != 0 && hold_cnt == HOLD_TOP && !(|(lock & grant)) && found;
    assign owner_nxt = !valid ? PARK : ((!own_req && found) || preempt) ? next : owner;
    assign hold_nxt  = (owner_nxt != owner || !own_req) ? '0 :
                       (found && hold_cnt != HOLD_TOP) ? hold_cnt + 1'b1 : hold_cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= PARK;
            hold_cnt <= '0;
            handover <= 1'b0;
        end else begin
            owner    <= owner_nxt;
            hold_cnt <= hold_nxt;
            handover <= owner_nxt != owner;
        end
    end
endmodule

// File: tb/tb_bus_arbiter_rr_n.sv
// tb_bus_arbiter_rr_n: directed checks of the round-robin arbiter with MAX_HOLD=4.
module tb_bus_arbiter_rr_n;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req, lock, grant;
    logic [1:0] owner;
    logic       handover;
    int         n_checks = 0;
    int         n_fail = 0;

    bus_arbiter_rr_n #(.NUM_MASTERS(4), .OWNER_W(2), .HOLD_W(8), .MAX_HOLD(4), .PARK_MASTER(0)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock),
        .grant(grant), .owner(owner), .handover(handover)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; req = '0; lock = '0;
        tick(); tick();
        chk("rst_grant", 32'(grant), 32'b0001);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_handover", 32'(handover), 0);
        reset = 1'b0;
        // parking
        for (int i = 0; i < 10; i++) tick();
        chk("park_grant", 32'(grant), 32'b0001);
        chk("park_handover", 32'(handover), 0);
        req = 4'b0100;
        tick();
        chk("park_req_grant", 32'(grant), 32'b0100);
        chk("park_req_owner", 32'(owner), 2);
        chk("park_req_handover", 32'(handover), 1);
        tick();
        chk("park_handover_drop", 32'(handover), 0);
        chk("park_keep_grant", 32'(grant), 32'b0100);
        // rotation
        req = 4'b0010;
        tick();
        chk("rot_owner1", 32'(owner), 1);
        req = 4'b1101;
        tick();
        chk("rot_owner2", 32'(owner), 2);
        req = 4'b1001;
        tick();
        chk("rot_owner3", 32'(owner), 3);
        req = 4'b0001;
        tick();
        chk("rot_owner0", 32'(owner), 0);
        chk("rot_wrap_grant", 32'(grant), 32'b0001);
        // hold limit: 4 cycles per owner under contention
        req = 4'b0011;
        chk("hold_start", 32'(grant), 32'b0001);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("hold_grant_%0d", i), 32'(grant), ((i / 4) % 2) != 0 ? 32'b0010 : 32'b0001);
            if (i % 4 == 0) chk($sformatf("hold_handover_%0d", i), 32'(handover), 1);
        end
        // lock keeps owner 0 past the hold limit
        lock = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("lock_grant_%0d", i), 32'(grant), 32'b0001);
        end
        lock = 4'b0000;
        tick();
        chk("unlock_owner", 32'(owner), 1);
        chk("unlock_handover", 32'(handover), 1);
        // locked owner dropping req loses the bus
        lock = 4'b0010; req = 4'b0001;
        tick();
        chk("lock_drop_req_owner", 32'(owner), 0);
        // reset mid-operation
        lock = 4'b0000; req = 4'b0100;
        tick();
        chk("mid_owner2", 32'(owner), 2);
        req = 4'b1111;
        tick(); tick(); tick();
        chk("mid_owner_held", 32'(owner), 2);
        reset = 1'b1;
        tick();
        chk("mid_rst_owner", 32'(owner), 0);
        chk("mid_rst_grant", 32'(grant), 32'b0001);
        chk("mid_rst_handover", 32'(handover), 0);
        reset = 1'b0;
        tick(); tick(); tick();
        chk("mid_hold_cleared", 32'(owner), 0);
        tick();
        chk("mid_preempt", 32'(owner), 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
